riscv_fetch_unit: RTL



---
 rtl/riscv_fetch_unit_if.sv | 43 ++++
 rtl/riscv_fetch_unit.sv | 109 ++++++++++
 2 files changed

// File: rtl/riscv_fetch_unit_if.sv
// riscv_fetch_unit_if: instruction memory channel and IF/ID bundle.
// master = fetch unit side, slave = memory / core side.
interface riscv_fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        ifid_valid;
  logic [31:0] ifid_ir;
  logic [63:0] ifid_pc;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data,
    input  stall,
    input  redirect,
    input  redirect_pc,
    output ifid_valid,
    output ifid_ir,
    output ifid_pc
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data,
    output stall,
    output redirect,
    output redirect_pc,
    input  ifid_valid,
    input  ifid_ir,
    input  ifid_pc
  );
endinterface

// File: rtl/riscv_fetch_unit.sv
// riscv_fetch_unit: in-order fetch with prefetch FIFO,
// credit-limited requests, stall hold and redirect flush.
module riscv_fetch_unit #(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [63:0] RESET_PC        = 64'h0,
  parameter logic [31:0] NOP_INSTR       = 32'h0000_0013
) (
  input logic                clock,
  input logic                reset_n,
  riscv_fetch_unit_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [OW-1:0] MAXO_C = OW'(MAX_OUTSTANDING);

  logic [63:0]   r_fetch_pc;
  logic [63:0]   r_resp_pc;
  logic [63:0]   r_last_pc;
  logic [31:0]   r_ir [DEPTH];
  logic [63:0]   r_pc [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [OW-1:0] r_outst;
  logic [OW-1:0] r_discard;

  logic        w_empty;
  logic        w_full;
  logic [31:0] w_inflight;
  logic        w_credit;
  logic        w_req;
  logic        w_fire;
  logic        w_resp;
  logic        w_drop;
  logic        w_push;
  logic        w_pop;
  logic [63:0] w_head_pc;
  logic [63:0] w_redir_pc;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == FULL_C);
  assign w_inflight = 32'(r_count) + 32'(r_outst);
  assign w_credit   = (r_outst < MAXO_C)
                   && (w_inflight < 32'(DEPTH));
  assign w_req      = reset_n && !bus.redirect && w_credit;
  assign w_fire     = w_req && bus.imem_req_ready;
  // A response with nothing outstanding is stale.
  assign w_resp     = bus.imem_resp_valid && (r_outst != '0);
  assign w_drop     = w_resp && (r_discard != '0);
  assign w_push     = w_resp && !w_drop && !bus.redirect;
  assign w_pop      = !w_empty && !bus.stall && !bus.redirect;
  assign w_head_pc  = r_pc[r_rptr];
  assign w_redir_pc = {bus.redirect_pc[63:2], 2'b00};

  assign bus.imem_req_valid = w_req;
  assign bus.imem_req_addr  = r_fetch_pc;
  assign bus.ifid_valid     = !w_empty;
  assign bus.ifid_ir        = w_empty ? NOP_INSTR : r_ir[r_rptr];
  assign bus.ifid_pc        = w_empty ? r_last_pc : w_head_pc;

  // FIFO payload storage, written on each accepted response.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_ir[r_wptr] <= bus.imem_resp_data;
      r_pc[r_wptr] <= r_resp_pc;
    end
  end

  // PCs, pointers, occupancy and credit/discard bookkeeping.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_last_pc  <= RESET_PC;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_outst    <= '0;
      r_discard  <= '0;
    end else begin
      r_outst <= r_outst + OW'(w_fire) - OW'(w_resp);
      if (!w_empty) r_last_pc <= w_head_pc;
      if (bus.redirect) begin
        r_fetch_pc <= w_redir_pc;
        r_resp_pc  <= w_redir_pc;
        r_wptr     <= '0;
        r_rptr     <= '0;
        r_count    <= '0;
        r_discard  <= r_outst - OW'(w_resp);
      end else begin
        if (w_fire) r_fetch_pc <= r_fetch_pc + 64'd4;
        if (w_push) begin
          r_resp_pc <= r_resp_pc + 64'd4;
          r_wptr    <= r_wptr + AW'(1);
        end
        if (w_pop) r_rptr <= r_rptr + AW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
        if (w_drop) r_discard <= r_discard - OW'(1);
      end
    end
  end

  a_no_overflow: assert property (
    @(posedge clock) disable iff (!reset_n)
    !(w_push && w_full));
endmodule
